// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM controller.
// Default sizing, counter direction encoding and sizing helpers.
package pwm_pkg;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int MAX          = (1 << DEF_WIDTH) - 1;
    localparam int SEL_W        = (DEF_CHANNELS > 1) ? $clog2(DEF_CHANNELS) : 1;

    typedef enum logic {
        UP = 1'b0,
        DN = 1'b1
    } dir_e;

    function automatic int max_of(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic int sel_w_of(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: pending (shadow) duty with saturating edits,
// active duty reloaded at period start, registered compare output.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             edit_en,
    input  logic             up,
    input  logic             dn,
    input  logic             reload,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm,
    output logic [WIDTH-1:0] shadow
);

    localparam logic [WIDTH:0]   MAXW   = (WIDTH+1)'(max_of(WIDTH));
    localparam logic [WIDTH:0]   STEPW  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MAXN   = WIDTH'(max_of(WIDTH));

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;
    logic [WIDTH:0]   sum;

    // Saturating edit of the pending duty, reload and compare
    always_comb begin
        sum      = {1'b0, shadow_q} + STEPW;
        shadow_d = shadow_q;
        active_d = reload ? shadow_q : active_q;
        pwm_d    = (cnt < active_q);
        if (edit_en && up && !dn) begin
            shadow_d = (sum > MAXW) ? MAXN : sum[WIDTH-1:0];
        end else if (edit_en && dn && !up) begin
            shadow_d = ({1'b0, shadow_q} < STEPW) ? '0
                     : shadow_q - WIDTH'(STEP);
        end
    end

    // Channel state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm    = pwm_q;
    assign shadow = shadow_q;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM top: prescaler, shared period counter with
// edge/centre-aligned direction FSM, channel select and duty readback.
module pwm_multi_ctrl
    import pwm_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 8,
    parameter int PRESCALE  = 128,
    parameter int STEP      = 5,
    parameter int CENTER    = 0,
    localparam int SW       = sel_w_of(CHANNELS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                up_pulse,
    input  logic                dn_pulse,
    input  logic                sel_pulse,
    output logic [CHANNELS-1:0] PWM_PIN,
    output logic [SW-1:0]       sel_ch,
    output logic [WIDTH-1:0]    duty_out,
    output logic                period_strobe
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] CMAX = WIDTH'(max_of(WIDTH));
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [PW-1:0]    pre_q, pre_d;
    logic             tick;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    logic             strobe_q, strobe_d;
    logic             reload;
    logic [SW-1:0]    sel_q, sel_d;
    logic [WIDTH-1:0] shadow_w [CHANNELS];

    // Prescaler: one-cycle tick every PRESCALE clocks
    always_comb begin
        tick  = (pre_q == PW'(PRESCALE - 1));
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    // Period counter and direction; reload when the count returns to 0
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (tick) begin
            if (CENTER == 0) begin
                cnt_d = cnt_q + ONE;
            end else begin
                unique case (dir_q)
                    UP: begin
                        if (cnt_q == CMAX) begin
                            cnt_d = cnt_q - ONE;
                            dir_d = (cnt_q == ONE) ? UP : DN;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                    DN: begin
                        cnt_d = cnt_q - ONE;
                        if (cnt_q == ONE) dir_d = UP;
                    end
                endcase
            end
        end
        reload   = tick && (cnt_d == '0);
        strobe_d = reload;
    end

    // Channel select advance with wrap
    always_comb begin
        sel_d = sel_q;
        if (sel_pulse) begin
            sel_d = (sel_q == SW'(CHANNELS - 1)) ? '0 : sel_q + SW'(1);
        end
    end

    // Top-level state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_q    <= '0;
            cnt_q    <= '0;
            dir_q    <= UP;
            strobe_q <= 1'b0;
            sel_q    <= '0;
        end else begin
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            strobe_q <= strobe_d;
            sel_q    <= sel_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .WIDTH (WIDTH),
            .STEP  (STEP)
        ) u_ch (
            .CLK     (CLK),
            .RST     (RST),
            .edit_en (sel_q == SW'(i)),
            .up      (up_pulse),
            .dn      (dn_pulse),
            .reload  (reload),
            .cnt     (cnt_q),
            .pwm     (PWM_PIN[i]),
            .shadow  (shadow_w[i])
        );
    end

    // Pending duty of the selected channel
    always_comb begin
        duty_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_q == SW'(i)) duty_out = shadow_w[i];
        end
    end

    assign sel_ch        = sel_q;
    assign period_strobe = strobe_q;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl: edge-aligned and centre-aligned
// instances, scoreboard of expected duty/select after each strobe.
module tb_pwm_multi_ctrl;

    typedef struct {
        int sel;
        int duty;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       up = 1'b0, dn = 1'b0, sel = 1'b0;
    logic [3:0] pin;
    logic [1:0] sel_ch;
    logic [7:0] duty;
    logic       strobe;

    logic       c_up = 1'b0, c_dn = 1'b0;
    logic       c_selp = 1'b0;
    logic [3:0] c_pin;
    logic [1:0] c_sel_ch;
    logic [7:0] c_duty;
    logic       c_strobe;

    int   checks = 0;
    int   passed = 0;
    int   m_sh [4];
    int   m_sel = 0;
    int   c_sh  = 0;
    exp_t sb [$];
    exp_t csb [$];

    always #5 CLK = ~CLK;

    pwm_multi_ctrl #(
        .CHANNELS (4), .WIDTH (8), .PRESCALE (4), .STEP (5), .CENTER (0)
    ) u_edge (
        .CLK (CLK), .RST (RST),
        .up_pulse (up), .dn_pulse (dn), .sel_pulse (sel),
        .PWM_PIN (pin), .sel_ch (sel_ch), .duty_out (duty),
        .period_strobe (strobe)
    );

    pwm_multi_ctrl #(
        .CHANNELS (4), .WIDTH (8), .PRESCALE (4), .STEP (4), .CENTER (1)
    ) u_ctr (
        .CLK (CLK), .RST (RST),
        .up_pulse (c_up), .dn_pulse (c_dn), .sel_pulse (c_selp),
        .PWM_PIN (c_pin), .sel_ch (c_sel_ch), .duty_out (c_duty),
        .period_strobe (c_strobe)
    );

    function automatic int sat(input int v);
        if (v > 255) return 255;
        if (v < 0) return 0;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_sh[i] = 0;
        m_sel = 0;
        c_sh  = 0;
        sb.delete();
        csb.delete();
    endtask

    task automatic edge_step(input string tag, input bit u, input bit d,
                             input bit s);
        exp_t e;
        @(negedge CLK);
        up  = u;
        dn  = d;
        sel = s;
        if (u && !d) m_sh[m_sel] = sat(m_sh[m_sel] + 5);
        if (d && !u) m_sh[m_sel] = sat(m_sh[m_sel] - 5);
        if (s) m_sel = (m_sel + 1) % 4;
        e.sel  = m_sel;
        e.duty = m_sh[m_sel];
        sb.push_back(e);
        @(negedge CLK);
        up  = 1'b0;
        dn  = 1'b0;
        sel = 1'b0;
        e = sb.pop_front();
        check({tag, "_sel"}, 32'(sel_ch), e.sel);
        check({tag, "_duty"}, 32'(duty), e.duty);
    endtask

    task automatic ctr_step(input string tag, input bit u, input bit d);
        exp_t e;
        @(negedge CLK);
        c_up = u;
        c_dn = d;
        if (u && !d) c_sh = sat(c_sh + 4);
        if (d && !u) c_sh = sat(c_sh - 4);
        e.sel  = 0;
        e.duty = c_sh;
        csb.push_back(e);
        @(negedge CLK);
        c_up = 1'b0;
        c_dn = 1'b0;
        e = csb.pop_front();
        check({tag, "_duty"}, 32'(c_duty), e.duty);
    endtask

    task automatic wait_strobe(input string tag, input bit ctr,
                               input int bound, output int n);
        logic s;
        n = 0;
        s = 1'b0;
        while (!s && n < bound) begin
            @(negedge CLK);
            n++;
            s = ctr ? c_strobe : strobe;
        end
        check({tag, "_strobe_seen"}, 32'(s), 1);
    endtask

    initial begin
        int n, hi, total, run, r_run, first_hi;
        bit in_first;

        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_pin", 32'(pin), 0);
        check("rst_sel", 32'(sel_ch), 0);
        check("rst_duty", 32'(duty), 0);
        check("rst_strobe", 32'(strobe), 0);
        check("rst_cpin", 32'(c_pin), 0);
        RST = 1'b0;

        // duty 15 on channel 0, loaded only at the next reload
        for (int i = 0; i < 3; i++) edge_step("t2_up", 1, 0, 0);
        check("t2_pin_pending", 32'(pin[0]), 0);
        wait_strobe("t2", 0, 1100, n);
        check("t2_pin_at_strobe", 32'(pin[0]), 0);
        hi = 0;
        first_hi = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge CLK);
            if (i == 0) first_hi = int'(pin[0]);
            hi += int'(pin[0]);
        end
        check("t2_pin_after_reload", first_hi, 1);
        check("t2_high_clks", hi, 60);

        // async reset while channel 0 is high
        n = 0;
        while (pin[0] !== 1'b1 && n < 1100) begin
            @(negedge CLK);
            n++;
        end
        check("t1_pin_high", 32'(pin[0]), 1);
        #2 RST = 1'b1;
        #1;
        check("t1_pin", 32'(pin), 0);
        check("t1_sel", 32'(sel_ch), 0);
        check("t1_duty", 32'(duty), 0);
        check("t1_strobe", 32'(strobe), 0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        wait_strobe("t1", 0, 1100, n);
        check("t1_first_strobe_clks", n, 1024);
        @(negedge CLK);
        check("t1_strobe_width", 32'(strobe), 0);

        // channel select walk and per-channel isolation
        for (int i = 0; i < 4; i++) edge_step("t4_sel", 0, 0, 1);
        edge_step("t4_sel", 0, 0, 1);
        edge_step("t4_sel", 0, 0, 1);
        edge_step("t4_up2", 1, 0, 0);
        wait_strobe("t4", 0, 1100, n);
        @(negedge CLK);
        check("t4_pins", 32'(pin), 32'h4);

        // simultaneous strobes
        edge_step("t5_updn", 1, 1, 0);
        for (int i = 0; i < 3; i++) edge_step("t5_sel", 0, 0, 1);
        edge_step("t5_selup", 1, 0, 1);
        for (int i = 0; i < 3; i++) edge_step("t5_back", 0, 0, 1);

        // saturation on channel 0
        for (int i = 0; i < 3; i++) edge_step("t3_sel", 0, 0, 1);
        for (int i = 0; i < 52; i++) edge_step("t3_up", 1, 0, 0);
        edge_step("t3_up_sat", 1, 0, 0);
        for (int i = 0; i < 51; i++) edge_step("t3_dn", 0, 1, 0);
        edge_step("t3_dn_floor", 0, 1, 0);

        // centre-aligned instance, duty 64
        for (int i = 0; i < 16; i++) ctr_step("t6_up", 1, 0);
        wait_strobe("t6a", 1, 2200, n);
        wait_strobe("t6b", 1, 2200, n);
        hi       = int'(c_pin[0]);
        total    = hi;
        run      = hi;
        r_run    = hi;
        in_first = (hi == 1);
        n        = 0;
        while (n < 2200) begin
            @(negedge CLK);
            n++;
            if (c_strobe) break;
            hi = int'(c_pin[0]);
            total += hi;
            run = hi ? run + 1 : 0;
            if (in_first) begin
                if (hi == 1) r_run++;
                else in_first = 1'b0;
            end
        end
        check("t6_period_clks", n, 2040);
        check("t6_high_clks", total, 508);
        check("t6_high_after_zero", r_run, 257);
        check("t6_high_before_zero", run, 251);

        // centre instance: saturation then floor from 3
        for (int i = 0; i < 48; i++) ctr_step("t3c_up", 1, 0);
        for (int i = 0; i < 63; i++) ctr_step("t3c_dn", 0, 1);
        ctr_step("t3c_dn_floor", 0, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
